regfile_write_buffer: RTL and testbench

- Write-side companion to the register file: collects writeback results from the ALU path and the memory/load path.
- Queues results in a small in-order FIFO and drains one entry per cycle onto the register file's single write port (`rf_write`/`rf_dest`/`rf_data`).
- Offers a forwarding lookup so decode can see results that are still queued and not yet written.

---
 rtl/regfile_write_buffer.sv | 134 +++++++++++++
 tb/tb_regfile_write_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_buffer.sv
// rtl/regfile_write_buffer.sv - in-order writeback queue feeding the register file write port
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   mem_valid/dest/data, ready   memory-path writeback request / accept
//   alu_valid/dest/data, ready   ALU-path writeback request / accept
//   rf_write, rf_dest, rf_data   registered register-file write port
//   src1, src2                   forwarding lookup addresses
//   fwd1_hit/data, fwd2_hit/data youngest pending value per lookup
//   count                        current queue occupancy
module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic [4:0]       mem_dest,
    input  logic [31:0]      mem_data,
    output logic             mem_ready,
    input  logic             alu_valid,
    input  logic [4:0]       alu_dest,
    input  logic [31:0]      alu_data,
    output logic             alu_ready,
    output logic             rf_write,
    output logic [4:0]       rf_dest,
    output logic [31:0]      rf_data,
    input  logic [4:0]       src1,
    input  logic [4:0]       src2,
    output logic             fwd1_hit,
    output logic [31:0]      fwd1_data,
    output logic             fwd2_hit,
    output logic [31:0]      fwd2_data,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] OCC_LAST = (PTR_W + 1)'(DEPTH - 1);

    logic [4:0]       q_dest [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] alu_slot;
    logic [PTR_W:0]   occ;
    logic [PTR_W:0]   n_push;
    logic             mem_push;
    logic             alu_push;
    logic             pop;

    assign count = occ;

    // Readiness looks only at the occupancy at the start of the cycle; the
    // concurrent pop is deliberately ignored. The ALU path reserves room for
    // the mem entry only when that entry would actually be enqueued.
    always_comb begin
        mem_ready = (occ < OCC_FULL);
        alu_ready = (mem_valid && (mem_dest != 5'd0)) ? (occ < OCC_LAST)
                                                      : (occ < OCC_FULL);
        // Writes to register 0 are accepted but never stored.
        mem_push  = mem_valid && mem_ready && (mem_dest != 5'd0);
        alu_push  = alu_valid && alu_ready && (alu_dest != 5'd0);
        pop       = (occ != '0);
        n_push    = (PTR_W + 1)'(mem_push) + (PTR_W + 1)'(alu_push);
        // The mem entry is older, so the ALU entry lands behind it.
        alu_slot  = tail + PTR_W'(mem_push);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (mem_push) begin
                q_dest[tail] <= mem_dest;
                q_data[tail] <= mem_data;
            end
            if (alu_push) begin
                q_dest[alu_slot] <= alu_dest;
                q_data[alu_slot] <= alu_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            rf_write <= 1'b0;
            rf_dest  <= 5'd0;
            rf_data  <= 32'd0;
        end else begin
            if (pop) begin
                rf_write <= 1'b1;
                rf_dest  <= q_dest[head];
                rf_data  <= q_data[head];
                head     <= head + 1'b1;
            end else begin
                rf_write <= 1'b0;
            end
            tail <= tail + PTR_W'(n_push);
            occ  <= occ + n_push - (PTR_W + 1)'(pop);
        end
    end

    // Scan from the output register through head to tail; later matches
    // overwrite earlier ones so the youngest pending value wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd1_hit  = 1'b0;
        fwd1_data = 32'd0;
        fwd2_hit  = 1'b0;
        fwd2_data = 32'd0;
        if (rf_write && (rf_dest == src1) && (src1 != 5'd0)) begin
            fwd1_hit  = 1'b1;
            fwd1_data = rf_data;
        end
        if (rf_write && (rf_dest == src2) && (src2 != 5'd0)) begin
            fwd2_hit  = 1'b1;
            fwd2_data = rf_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W + 1)'(i) < occ) && (q_dest[idx] == src1) && (src1 != 5'd0)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = q_data[idx];
            end
            if (((PTR_W + 1)'(i) < occ) && (q_dest[idx] == src2) && (src2 != 5'd0)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = q_data[idx];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb/tb_regfile_write_buffer.sv - self-checking bench for regfile_write_buffer
module tb_regfile_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, alu_valid;
    logic [4:0]  mem_dest, alu_dest, src1, src2;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, rf_write, fwd1_hit, fwd2_hit;
    logic [4:0]  rf_dest;
    logic [31:0] rf_data, fwd1_data, fwd2_data;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    regfile_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
        .rf_write(rf_write), .rf_dest(rf_dest), .rf_data(rf_data),
        .src1(src1), .src2(src2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv;
        logic [4:0]  md;
        logic [31:0] mdat;
        logic        av;
        logic [4:0]  ad;
        logic [31:0] adat;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        mr;
        logic        ar;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
        logic        w;
        logic [4:0]  rd;
        logic [31:0] rdat;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                         input logic av, input logic [4:0] ad, input logic [31:0] adat,
                         input logic [4:0] s1, input logic [4:0] s2);
        @(negedge clk);
        mem_valid = mv; mem_dest = md; mem_data = mdat;
        alu_valid = av; alu_dest = ad; alu_data = adat;
        src1 = s1; src2 = s2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag, input logic w, input logic [4:0] rd,
                            input logic [31:0] rdat, input logic [2:0] cnt);
        check({tag, " rf_write"}, 32'(rf_write), 32'(w));
        if (w) begin
            check({tag, " rf_dest"}, 32'(rf_dest), 32'(rd));
            check({tag, " rf_data"}, rf_data, rdat);
        end
        check({tag, " count"}, 32'(count), 32'(cnt));
    endtask

    initial begin
        //            mv md mdat          av ad adat          s1 s2  mr ar h1 d1            h2 d2            w  rd rdat          cnt
        vecs[0]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0};
        vecs[1]  = '{1, 5, 32'hAAAA0001, 0, 0, 32'h0,        5, 0,  1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1};
        vecs[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,        5, 0,  1, 1, 1, 32'hAAAA0001, 0, 32'h0,        1, 5, 32'hAAAA0001, 0};
        vecs[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,        5, 5,  1, 1, 1, 32'hAAAA0001, 1, 32'hAAAA0001, 0, 5, 32'hAAAA0001, 0};
        vecs[4]  = '{1, 3, 32'h11,       1, 3, 32'h22,       3, 0,  1, 1, 0, 32'h0,        0, 32'h0,        0, 5, 32'hAAAA0001, 2};
        vecs[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,        3, 5,  1, 1, 1, 32'h22,       0, 32'h0,        1, 3, 32'h11,       1};
        vecs[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,        3, 3,  1, 1, 1, 32'h22,       1, 32'h22,       1, 3, 32'h22,       0};
        vecs[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,        3, 0,  1, 1, 1, 32'h22,       0, 32'h0,        0, 3, 32'h22,       0};
        vecs[8]  = '{0, 0, 32'h0,        1, 0, 32'hDEAD,     0, 3,  1, 1, 0, 32'h0,        0, 32'h0,        0, 3, 32'h22,       0};
        vecs[9]  = '{1, 0, 32'hBEEF,     1, 9, 32'h99,       0, 9,  1, 1, 0, 32'h0,        0, 32'h0,        0, 3, 32'h22,       1};
        vecs[10] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 9,  1, 1, 0, 32'h0,        1, 32'h99,       1, 9, 32'h99,       0};

        reset = 1'b1;
        mem_valid = 0; mem_dest = 0; mem_data = 0;
        alu_valid = 0; alu_dest = 0; alu_data = 0;
        src1 = 0; src2 = 0;
        tick();
        tick();
        check("reset count", 32'(count), 32'd0);
        check("reset rf_write", 32'(rf_write), 32'd0);
        check("reset rf_dest", 32'(rf_dest), 32'd0);
        check("reset rf_data", rf_data, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Table: single write, dual same-dest write, dest-0 drops, forwarding.
        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].mv, vecs[i].md, vecs[i].mdat, vecs[i].av, vecs[i].ad, vecs[i].adat,
                  vecs[i].s1, vecs[i].s2);
            check({tag, " mem_ready"}, 32'(mem_ready), 32'(vecs[i].mr));
            check({tag, " alu_ready"}, 32'(alu_ready), 32'(vecs[i].ar));
            check({tag, " fwd1_hit"}, 32'(fwd1_hit), 32'(vecs[i].h1));
            check({tag, " fwd1_data"}, fwd1_data, vecs[i].d1);
            check({tag, " fwd2_hit"}, 32'(fwd2_hit), 32'(vecs[i].h2));
            check({tag, " fwd2_data"}, fwd2_data, vecs[i].d2);
            tick();
            check({tag, " rf_write"}, 32'(rf_write), 32'(vecs[i].w));
            check({tag, " rf_dest"}, 32'(rf_dest), 32'(vecs[i].rd));
            check({tag, " rf_data"}, rf_data, vecs[i].rdat);
            check({tag, " count"}, 32'(count), 32'(vecs[i].cnt));
        end

        // Back-to-back ALU writes 1..6, wrapping the pointers.
        for (int k = 1; k <= 6; k++) begin
            drive(0, 0, 0, 1, 5'(k), 32'h100 + 32'(k), 5'(k), 0);
            check($sformatf("wrap%0d alu_ready", k), 32'(alu_ready), 32'd1);
            check($sformatf("wrap%0d fwd1_hit", k), 32'(fwd1_hit), 32'd0);
            tick();
            check($sformatf("wrap%0d count", k), 32'(count), 32'd1);
            if (k > 1)
                check_rf($sformatf("wrap%0d", k), 1, 5'(k - 1), 32'h100 + 32'(k - 1), 3'd1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_rf("wrap drain", 1, 5'd6, 32'h106, 3'd0);

        // Occupancy 3: mem accepted, alu held back until mem goes idle.
        drive(1, 10, 32'hA, 1, 11, 32'hB, 0, 0);
        tick();
        check("fill1 count", 32'(count), 32'd2);
        drive(1, 12, 32'hC, 1, 13, 32'hD, 0, 0);
        check("fill2 alu_ready", 32'(alu_ready), 32'd1);
        tick();
        check_rf("fill2", 1, 5'd10, 32'hA, 3'd3);
        drive(1, 7, 32'h7, 1, 8, 32'h8, 0, 0);
        check("full mem_ready", 32'(mem_ready), 32'd1);
        check("full alu_ready", 32'(alu_ready), 32'd0);
        tick();
        check_rf("full", 1, 5'd11, 32'hB, 3'd3);
        drive(0, 0, 0, 1, 8, 32'h8, 7, 13);
        check("retry alu_ready", 32'(alu_ready), 32'd1);
        check("retry fwd1_hit", 32'(fwd1_hit), 32'd1);
        check("retry fwd1_data", fwd1_data, 32'h7);
        check("retry fwd2_hit", 32'(fwd2_hit), 32'd1);
        check("retry fwd2_data", fwd2_data, 32'hD);
        tick();
        check_rf("retry", 1, 5'd12, 32'hC, 3'd3);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_rf("drain1", 1, 5'd13, 32'hD, 3'd2);
        tick();
        check_rf("drain2", 1, 5'd7, 32'h7, 3'd1);
        tick();
        check_rf("drain3", 1, 5'd8, 32'h8, 3'd0);
        tick();
        check_rf("drain4", 0, 5'd8, 32'h8, 3'd0);

        // Reset with three queued entries discards them all.
        drive(1, 20, 32'h20, 1, 21, 32'h21, 0, 0);
        tick();
        check("rq1 count", 32'(count), 32'd2);
        drive(1, 22, 32'h22, 1, 23, 32'h23, 0, 0);
        tick();
        check_rf("rq2", 1, 5'd20, 32'h20, 3'd3);
        drive(0, 0, 0, 0, 0, 0, 21, 23);
        reset = 1'b1;
        tick();
        check("rq reset count", 32'(count), 32'd0);
        check("rq reset rf_write", 32'(rf_write), 32'd0);
        check("rq reset rf_dest", 32'(rf_dest), 32'd0);
        check("rq reset rf_data", rf_data, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0, 0, 21, 23);
            check($sformatf("rq post%0d fwd1_hit", c), 32'(fwd1_hit), 32'd0);
            check($sformatf("rq post%0d fwd2_hit", c), 32'(fwd2_hit), 32'd0);
            tick();
            check($sformatf("rq post%0d rf_write", c), 32'(rf_write), 32'd0);
            check($sformatf("rq post%0d count", c), 32'(count), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
